// File: rtl/alu_flag_stage_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU flag/result stage:
//   - bit positions of N, Z, C, V inside the 4-bit flag vector {N,Z,C,V}
//   - alu_flags_t / flag_entry_t storage types
//   - skid buffer state encoding
//   - pack_entry helper that assembles one buffered entry
// Optional feature macro used by the stage: ALU_STICKY_OF_EN.
// ---------------------------------------------------------------------------
package alu_pkg;

  // Datapath width of the subtractor feeding the stage.
  localparam int ALU_W = 32;

  // Flag vector layout is {N, Z, C, V}, so V is the LSB.
  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  typedef logic [3:0] alu_flags_t;

  typedef struct packed {
    logic [ALU_W-1:0] s;
    alu_flags_t       flags;
    logic             lt;
    logic             ltu;
  } flag_entry_t;

  // Occupancy of the two-entry skid buffer.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  // Assemble one buffer entry from its decoded parts.
  function automatic flag_entry_t pack_entry(
    input logic [ALU_W-1:0] s,
    input alu_flags_t       flags,
    input logic             lt,
    input logic             ltu
  );
    flag_entry_t e;
    e.s     = s;
    e.flags = flags;
    e.lt    = lt;
    e.ltu   = ltu;
    return e;
  endfunction

endpackage

// File: rtl/alu_flag_stage_decode.sv
// ---------------------------------------------------------------------------
// alu_flag_decode
// Combinational derivation of NZCV and the signed/unsigned less-than results
// from the raw subtractor outputs.
// Ports:
//   s       in  W  difference a - b
//   cary    in  1  carry out of a + (0-b)
//   of      in  1  signed overflow
//   eq      in  1  a == b
//   b_zero  in  1  subtrahend is zero
//   flags   out 4  {N, Z, C, V}
//   lt      out 1  signed a < b
//   ltu     out 1  unsigned a < b
// ---------------------------------------------------------------------------
module alu_flag_decode
  import alu_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  logic [W-1:0] s,
  input  logic         cary,
  input  logic         of,
  input  logic         eq,
  input  logic         b_zero,
  output alu_flags_t   flags,
  output logic         lt,
  output logic         ltu
);

  logic n_s;
  logic z_s;
  logic c_s;
  logic v_s;

  // Flag and compare derivation from the subtractor outputs.
  always_comb begin
    n_s = s[W-1];
    z_s = eq;
    v_s = of;
    // The subtractor forms a + (0-b); for b == 0 the negation yields no
    // carry even though no borrow occurred, so b_zero forces C.
    c_s = cary | b_zero;

    flags         = 4'b0000;
    flags[FLAG_N] = n_s;
    flags[FLAG_Z] = z_s;
    flags[FLAG_C] = c_s;
    flags[FLAG_V] = v_s;

    lt  = n_s ^ v_s;
    ltu = ~c_s;
  end

endmodule

// File: rtl/alu_flag_stage.sv
// ---------------------------------------------------------------------------
// alu_flag_stage
// Registered flag/result stage behind the 32-bit subtractor ALU. Each accepted
// result is decoded into NZCV plus signed/unsigned compare bits and held in a
// two-entry skid buffer so the consumer may stall while in_ready stays a pure
// flop output.
// Optional feature (macro ALU_STICKY_OF_EN): sticky overflow bit and a
// saturating 16-bit overflow event counter, cleared by of_clr.
// Ports:
//   clk        in   1  rising-edge clock
//   rst_n      in   1  synchronous active-low reset
//   in_valid   in   1  subtractor outputs valid
//   in_ready   out  1  stage can accept (flop)
//   s          in   W  difference
//   cary       in   1  carry out of a + (0-b)
//   of         in   1  signed overflow
//   eq         in   1  a == b
//   b_zero     in   1  subtrahend is zero
//   out_valid  out  1  output entry valid
//   out_ready  in   1  consumer accepts output entry
//   out_s      out  W  registered difference
//   out_flags  out  4  {N, Z, C, V}
//   out_lt     out  1  signed a < b
//   out_ltu    out  1  unsigned a < b
//   sticky_of  out  1  (ALU_STICKY_OF_EN) overflow seen since clear
//   of_count   out 16  (ALU_STICKY_OF_EN) saturating overflow count
//   of_clr     in   1  (ALU_STICKY_OF_EN) clear sticky_of and of_count
// W must equal alu_pkg::ALU_W since the buffer entries use the package type.
// ---------------------------------------------------------------------------
module alu_flag_stage
  import alu_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] s,
  input  logic         cary,
  input  logic         of,
  input  logic         eq,
  input  logic         b_zero,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_s,
  output logic [3:0]   out_flags,
  output logic         out_lt,
`ifdef ALU_STICKY_OF_EN
  output logic         sticky_of,
  output logic [15:0]  of_count,
  input  logic         of_clr,
`endif
  output logic         out_ltu
);

  localparam logic [1:0] S_EMPTY = BUF_EMPTY;
  localparam logic [1:0] S_ONE   = BUF_ONE;
  localparam logic [1:0] S_TWO   = BUF_TWO;

  logic [1:0]  state_r;
  logic [1:0]  state_nxt_s;
  logic        in_ready_r;
  logic        out_valid_r;
  flag_entry_t main_r;
  flag_entry_t skid_r;
  flag_entry_t cap_s;

  alu_flags_t  dec_flags_s;
  logic        dec_lt_s;
  logic        dec_ltu_s;

  logic        accept_s;
  logic        xfer_s;
  logic        load_main_s;
  logic        load_skid_s;
  logic        skid_to_main_s;

  alu_flag_decode #(
    .W (W)
  ) u_decode (
    .s      (s),
    .cary   (cary),
    .of     (of),
    .eq     (eq),
    .b_zero (b_zero),
    .flags  (dec_flags_s),
    .lt     (dec_lt_s),
    .ltu    (dec_ltu_s)
  );

  assign cap_s    = pack_entry(s, dec_flags_s, dec_lt_s, dec_ltu_s);
  assign accept_s = in_valid & in_ready_r;
  assign xfer_s   = out_valid_r & out_ready;

  // Skid buffer next-state and load-select decode.
  always_comb begin
    state_nxt_s    = state_r;
    load_main_s    = 1'b0;
    load_skid_s    = 1'b0;
    skid_to_main_s = 1'b0;
    case (state_r)
      S_EMPTY: begin
        if (accept_s) begin
          state_nxt_s = S_ONE;
          load_main_s = 1'b1;
        end else begin
          state_nxt_s = S_EMPTY;
        end
      end
      S_ONE: begin
        if (accept_s && !xfer_s) begin
          state_nxt_s = S_TWO;
          load_skid_s = 1'b1;
        end else if (accept_s && xfer_s) begin
          // Head leaves while the new entry replaces it directly.
          state_nxt_s = S_ONE;
          load_main_s = 1'b1;
        end else if (xfer_s) begin
          state_nxt_s = S_EMPTY;
        end else begin
          state_nxt_s = S_ONE;
        end
      end
      S_TWO: begin
        // in_ready is low here, so no accept can coincide with the transfer.
        if (xfer_s) begin
          state_nxt_s    = S_ONE;
          skid_to_main_s = 1'b1;
        end else begin
          state_nxt_s = S_TWO;
        end
      end
      default: begin
        state_nxt_s = S_EMPTY;
      end
    endcase
  end

  // State, handshake flops and entry storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= S_EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      main_r      <= '0;
      skid_r      <= '0;
    end else begin
      state_r     <= state_nxt_s;
      // Handshake outputs are registered from the next state so neither
      // depends combinationally on out_ready.
      in_ready_r  <= (state_nxt_s != S_TWO);
      out_valid_r <= (state_nxt_s != S_EMPTY);
      if (load_main_s) begin
        main_r <= cap_s;
      end else if (skid_to_main_s) begin
        main_r <= skid_r;
      end else begin
        main_r <= main_r;
      end
      if (load_skid_s) begin
        skid_r <= cap_s;
      end else begin
        skid_r <= skid_r;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_s     = main_r.s;
  assign out_flags = main_r.flags;
  assign out_lt    = main_r.lt;
  assign out_ltu   = main_r.ltu;

`ifdef ALU_STICKY_OF_EN
  logic        sticky_of_r;
  logic [15:0] of_count_r;

  // Sticky overflow bit and saturating overflow counter; clear beats a
  // simultaneous overflow event.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_of_r <= 1'b0;
      of_count_r  <= 16'h0000;
    end else if (of_clr) begin
      sticky_of_r <= 1'b0;
      of_count_r  <= 16'h0000;
    end else if (accept_s && dec_flags_s[FLAG_V]) begin
      sticky_of_r <= 1'b1;
      if (of_count_r != 16'hFFFF) begin
        of_count_r <= of_count_r + 16'h0001;
      end else begin
        of_count_r <= of_count_r;
      end
    end else begin
      sticky_of_r <= sticky_of_r;
      of_count_r  <= of_count_r;
    end
  end

  assign sticky_of = sticky_of_r;
  assign of_count  = of_count_r;
`endif

endmodule

// File: tb/tb_alu_flag_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_flag_stage
// Self-checking bench for alu_flag_stage. Upstream operands a/b are turned
// into subtractor outputs; expected results come from plain arithmetic on
// a/b and the buffer is modelled as a FIFO of depth two.
// ---------------------------------------------------------------------------
module tb_alu_flag_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] s;
  logic        cary;
  logic        of;
  logic        eq;
  logic        b_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_s;
  logic [3:0]  out_flags;
  logic        out_lt;
  logic        out_ltu;
  logic        sticky_of;
  logic [15:0] of_count;
  logic        of_clr;

  int nchk = 0;
  int nerr = 0;

  typedef struct {
    logic [31:0] s;
    logic [3:0]  f;
    logic        lt;
    logic        ltu;
  } exp_t;

  exp_t q[$];
  int   m_count  = 0;
  bit   m_sticky = 1'b0;

  alu_flag_stage #(.W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s         (s),
    .cary      (cary),
    .of        (of),
    .eq        (eq),
    .b_zero    (b_zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_flags (out_flags),
    .out_lt    (out_lt),
`ifdef ALU_STICKY_OF_EN
    .sticky_of (sticky_of),
    .of_count  (of_count),
    .of_clr    (of_clr),
`endif
    .out_ltu   (out_ltu)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected entry from the operands, using ordinary integer comparisons.
  function automatic exp_t ref_of(input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint d;
    logic   v;
    e.s = a - b;
    d   = longint'($signed(a)) - longint'($signed(b));
    v   = (d > 64'sd2147483647) || (d < -64'sd2147483648);
    e.f = {e.s[31], (a == b), (a >= b), v};
    e.lt  = ($signed(a) < $signed(b));
    e.ltu = (a < b);
    return e;
  endfunction

  // Drive the subtractor outputs an upstream ALU would produce for a - b.
  task automatic drive_sub(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum    = {1'b0, a} + {1'b0, (32'd0 - b)};
    s      = sum[31:0];
    cary   = sum[32];
    of     = (a[31] != b[31]) && (sum[31] != a[31]);
    eq     = (a == b);
    b_zero = (b == 32'd0);
  endtask

  task automatic check_outputs();
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("out_s", out_s, q[0].s);
      chk("out_flags", out_flags, q[0].f);
      chk("out_lt", out_lt, q[0].lt);
      chk("out_ltu", out_ltu, q[0].ltu);
    end
`ifdef ALU_STICKY_OF_EN
    chk("sticky_of", sticky_of, m_sticky);
    chk("of_count", of_count, m_count);
`endif
  endtask

  // One clock: check state, drive inputs, clock, update model. Called #1
  // after a rising edge and returns #1 after the next one.
  task automatic cyc(input logic v, input logic r, input logic [31:0] a,
                     input logic [31:0] b, input logic clr, output bit acc);
    bit   xfer;
    exp_t e;
    check_outputs();
    in_valid  = v;
    out_ready = r;
    of_clr    = clr;
    drive_sub(a, b);
    e = ref_of(a, b);
    @(posedge clk);
    acc = 1'b0;
    if (!rst_n) begin
      q.delete();
      m_count  = 0;
      m_sticky = 1'b0;
    end else begin
      acc  = v && (q.size() < 2);
      xfer = (q.size() > 0) && r;
      if (xfer) void'(q.pop_front());
      if (acc) q.push_back(e);
      if (clr) begin
        m_count  = 0;
        m_sticky = 1'b0;
      end else if (acc && e.f[0]) begin
        m_sticky = 1'b1;
        if (m_count < 65535) m_count++;
      end
    end
    #1;
  endtask

  initial begin
    bit          acc;
    bit          pend;
    logic [31:0] ra;
    logic [31:0] rb;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; of_clr = 1'b0;
    s = 32'd0; cary = 1'b0; of = 1'b0; eq = 1'b0; b_zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_s", out_s, 32'd0);
    chk("rst_out_flags", out_flags, 4'b0000);
    chk("rst_out_lt", out_lt, 1'b0);
    chk("rst_out_ltu", out_ltu, 1'b0);
    rst_n = 1'b1;

    // Directed flag cases.
    cyc(1'b1, 1'b1, 32'd5, 32'd3, 1'b0, acc);
    chk("d1_s", out_s, 32'd2);
    chk("d1_flags", out_flags, 4'b0010);
    chk("d1_lt_ltu", {out_lt, out_ltu}, 2'b00);
    cyc(1'b1, 1'b1, 32'd3, 32'd5, 1'b0, acc);
    chk("d2_s", out_s, 32'hFFFFFFFE);
    chk("d2_flags", out_flags, 4'b1000);
    chk("d2_lt_ltu", {out_lt, out_ltu}, 2'b11);
    cyc(1'b1, 1'b1, 32'h80000000, 32'd1, 1'b0, acc);
    chk("d3_flags", out_flags, 4'b0011);
    chk("d3_lt_ltu", {out_lt, out_ltu}, 2'b10);
    cyc(1'b1, 1'b1, 32'd7, 32'd0, 1'b0, acc);
    chk("d4_C", out_flags[1], 1'b1);
    chk("d4_ltu", out_ltu, 1'b0);
    cyc(1'b0, 1'b1, 32'd0, 32'd0, 1'b0, acc);

    // Backpressure: three offers with the consumer stalled.
    cyc(1'b1, 1'b0, 32'd1, 32'd0, 1'b0, acc);
    chk("bp_acc1", acc, 1'b1);
    cyc(1'b1, 1'b0, 32'd2, 32'd0, 1'b0, acc);
    chk("bp_ready_low", in_ready, 1'b0);
    cyc(1'b1, 1'b0, 32'd3, 32'd0, 1'b0, acc);
    chk("bp_hold_s", out_s, 32'd1);
    cyc(1'b1, 1'b1, 32'd3, 32'd0, 1'b0, acc);
    chk("bp_no_acc_in_two", acc, 1'b0);
    chk("bp_second", out_s, 32'd2);
    cyc(1'b1, 1'b1, 32'd3, 32'd0, 1'b0, acc);
    chk("bp_third", out_s, 32'd3);
    cyc(1'b0, 1'b1, 32'd0, 32'd0, 1'b0, acc);
    chk("bp_drained", out_valid, 1'b0);

    // Random traffic; upstream holds an offer until it is accepted.
    pend = 1'b0; ra = 32'd0; rb = 32'd0;
    for (int i = 0; i < 400; i++) begin
      if (!pend) begin
        ra = $urandom;
        case ($urandom_range(0, 5))
          0: rb = 32'd0;
          1: rb = ra;
          2: rb = {~ra[31], ra[30:0]};
          default: rb = $urandom;
        endcase
        pend = ($urandom_range(0, 3) != 0);
      end
      cyc(pend, ($urandom_range(0, 3) != 0), ra, rb, 1'b0, acc);
      if (acc) pend = 1'b0;
    end
    cyc(1'b0, 1'b1, 32'd0, 32'd0, 1'b0, acc);
    cyc(1'b0, 1'b1, 32'd0, 32'd0, 1'b0, acc);

    // Reset while full.
    cyc(1'b1, 1'b0, 32'd10, 32'd1, 1'b0, acc);
    cyc(1'b1, 1'b0, 32'd20, 32'd1, 1'b0, acc);
    chk("two_ready_low", in_ready, 1'b0);
    rst_n = 1'b0;
    cyc(1'b1, 1'b1, 32'd30, 32'd1, 1'b0, acc);
    rst_n = 1'b1;
    chk("rst2_out_valid", out_valid, 1'b0);
    chk("rst2_in_ready", in_ready, 1'b1);
    chk("rst2_out_s", out_s, 32'd0);
    chk("rst2_out_flags", out_flags, 4'b0000);

    // Overflow events, then clear.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 32'h80000000, 32'd1, 1'b0, acc);
    cyc(1'b0, 1'b1, 32'd0, 32'd0, 1'b0, acc);
`ifdef ALU_STICKY_OF_EN
    chk("ofc_count3", of_count, 16'd3);
    chk("ofc_sticky", sticky_of, 1'b1);
`endif
    cyc(1'b1, 1'b1, 32'h80000000, 32'd1, 1'b1, acc);
    cyc(1'b0, 1'b1, 32'd0, 32'd0, 1'b0, acc);
`ifdef ALU_STICKY_OF_EN
    chk("ofc_clr_count", of_count, 16'd0);
    chk("ofc_clr_sticky", sticky_of, 1'b0);
`endif
    check_outputs();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/alu_flag_stage.md
# alu_flag_stage

Registered flag/result stage directly downstream of the 32-bit subtractor ALU. It captures the difference, carry, overflow and equality outputs, derives the NZCV flags and the signed/unsigned compare results, and presents them to the consumer. A valid/ready handshake with a two-entry skid buffer lets the consumer stall without combinational ready paths.

## Interface
- `W`, 32: datapath width; must match the subtractor width.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  the subtractor outputs and `b_zero` are valid this cycle.
- `in_ready`  out  1  the stage can accept a result; driven directly from a flop.
- `s`  in  W  difference from the subtractor.
- `cary`  in  1  carry out of `a + (0-b)`.
- `of`  in  1  signed overflow from the subtractor.
- `eq`  in  1  equality flag from the subtractor (`a == b`).
- `b_zero`  in  1  the subtrahend is zero; needed because `0-b` produces no carry when `b == 0`.
- `out_valid`  out  1  output entry is valid.
- `out_ready`  in  1  the consumer accepts the output entry.
- `out_s`  out  W  registered difference.
- `out_flags`  out  4  {N, Z, C, V}.
- `out_lt`  out  1  signed a < b.
- `out_ltu`  out  1  unsigned a < b.
- `sticky_of`  out  1  present only when `ALU_STICKY_OF_EN` is defined.
- `of_count`  out  16  present only when `ALU_STICKY_OF_EN` is defined.
- `of_clr`  in  1  present only when `ALU_STICKY_OF_EN` is defined.

## Operation
- Flag derivation at capture:
  - N = `s[W-1]`.
  - Z = `eq`.
  - V = `of`.
  - C = `cary | b_zero`, meaning "no borrow".
  - `lt` = N ^ V.
  - `ltu` = ~C.
- Input accept: `in_valid & in_ready`. Output transfer: `out_valid & out_ready`.
- The two-entry buffer has a main register (drives the outputs) and a skid register.
- States:
  - EMPTY: nothing held.
    - Accept → ONE.
  - ONE: main register holds an entry.
    - Accept without transfer → TWO; the new entry goes to skid.
    - Accept with transfer → ONE; the new entry goes to main.
    - Transfer without accept → EMPTY.
  - TWO: main and skid both hold entries; `in_ready` = 0.
    - Transfer → ONE; skid moves to main.
- `in_ready` = 1 in EMPTY and ONE, 0 in TWO. It is registered from the next state.
- `out_valid` = 1 in ONE and TWO.
- Ordering is strictly FIFO. No entry is dropped or duplicated.
- `in_valid` asserted while `in_ready` = 0 is ignored; the upstream holds its data.

## Timing
- Latency: an entry accepted at edge k is visible on the outputs after edge k, so `out_valid` is high in cycle k+1.
- Throughput: one entry per cycle when `out_ready` stays high.
- Output stability: while `out_valid & ~out_ready`, all `out_*` hold stable.
- Reset (`rst_n` = 0 at a rising edge):
  - state → EMPTY; `in_ready` → 1; `out_valid` → 0.
  - `out_s` → 0; `out_flags` → 0; `out_lt` → 0; `out_ltu` → 0.
  - `sticky_of` → 0; `of_count` → 0.
- Reset mid-transfer discards all held entries; no partial output.
- Reset has priority over every other event in the same cycle.
- In TWO, a simultaneous transfer and `in_valid` does not accept, because `in_ready` was 0 that cycle.

## Configuration
- `ALU_STICKY_OF_EN` defined:
  - `sticky_of` sets on any accepted entry with V = 1.
  - `of_count` increments per such entry and saturates at 0xFFFF.
  - `of_clr` = 1 clears both to 0. If an overflow entry is accepted in the same cycle, clear wins and the new event is lost.
- `ALU_STICKY_OF_EN` undefined: the ports and logic are absent and the buffer behaviour is identical.

## Structure
- Shared package `alu_pkg`:
  - `FLAG_N`, `FLAG_Z`, `FLAG_C`, `FLAG_V` bit-index constants.
  - Typedef `alu_flags_t` (4 bits).
  - Typedef `flag_entry_t` {s, flags, lt, ltu}.
  - State enum {EMPTY, ONE, TWO}.
- One sub-module: `alu_flag_decode`, combinational flag/compare derivation from `s`, `cary`, `of`, `eq`, `b_zero`.
- The skid buffer FSM stays in the top module.

## Test plan
- **a=5, b=3.** Drive s=0x00000002, cary=1, of=0, eq=0, b_zero=0 → one cycle later: out_s=2, flags=4'b0010, lt=0, ltu=0.
- **a=3, b=5.** Drive s=0xFFFFFFFE, cary=0, of=0, eq=0 → flags=4'b1000, lt=1, ltu=1.
- **a=0x80000000, b=1.** Drive s=0x7FFFFFFF, cary=1, of=1 → flags=4'b0011, lt=1, ltu=0.
- **a=7, b=0.** Drive s=7, cary=0, b_zero=1 → C=1, ltu=0.
- **Backpressure.** Hold `out_ready`=0 and stream 3 entries → `in_ready` falls after the 2nd accept. Release → entries emerge in order 1, 2, 3 with no gaps or duplicates.
- **Reset in TWO** → next cycle: out_valid=0, in_ready=1. With `ALU_STICKY_OF_EN`: 3 overflow entries → of_count=3, sticky_of=1; of_clr → both 0.
